banked_register_file: RTL and testbench

- Parametrised successor to the Mini SRC CPU's single-port register file.
- Provides one write port, two independently enabled registered read ports, optional hardwired-zero R0, and optional write-to-read bypass.
- Includes a sequential bulk-clear engine that zeroes the file one register per cycle.
- Sits between the datapath bus/ALU operand latches and the control unit.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clear_fsm.sv | 62 ++++++
 rtl/banked_register_file.sv | 123 ++++++++++++
 tb/tb_banked_register_file.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Types and helpers shared by the banked register file and its bulk-clear engine.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

    // Address width for n registers; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential bulk-clear engine: walks the register file zeroing one entry per cycle.
//
//   state | meaning
//   IDLE  | waiting; clr_req is level-sampled only here
//   CLEAR | clr_busy=1, zeroes reg[cnt] each edge, cnt counts 0..NUM_REGS-1
//   DONE  | clr_done=1 for one cycle, then back to IDLE
module regfile_clear_fsm import regfile_pkg::*; #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // One spare bit so NUM_REGS=256 cannot alias back to zero.
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NUM_REGS - 1);

    clr_state_t      state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE);
    assign clr_we   = clr_busy;
    assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/banked_register_file.sv
// Parametrised register file: one write port, two registered read ports,
// optional hardwired-zero R0, optional write-to-read bypass and a bulk-clear engine.
module banked_register_file import regfile_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = addr_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
    logic              rd_valid_a_q, rd_valid_b_q;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_eff;
    logic              ok_a, ok_b;

    // An address is backed by storage unless it is past the end or a hardwired R0.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    regfile_clear_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_eff = wr_en && !clr_busy && addr_live(wr_addr);
    assign ok_a   = addr_live(rd_addr_a);
    assign ok_b   = addr_live(rd_addr_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_we && (clr_addr == ADDR_W'(i))) begin
                    regs_q[i] <= '0;
                end else if (wr_eff && (wr_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    // Bypass only ever forwards datapath writes, never clear writes.
    always_comb begin
        rd_data_a_d = rd_data_a_q;
        if (rd_en_a) begin
            rd_data_a_d = '0;
            if (ok_a) begin
                if ((BYPASS != 0) && wr_eff && (wr_addr == rd_addr_a)) begin
                    rd_data_a_d = wr_data;
                end else begin
                    rd_data_a_d = regs_q[rd_addr_a];
                end
            end
        end
    end

    always_comb begin
        rd_data_b_d = rd_data_b_q;
        if (rd_en_b) begin
            rd_data_b_d = '0;
            if (ok_b) begin
                if ((BYPASS != 0) && wr_eff && (wr_addr == rd_addr_b)) begin
                    rd_data_b_d = wr_data;
                end else begin
                    rd_data_b_d = regs_q[rd_addr_b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_en_a;
            rd_valid_b_q <= rd_en_b;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench: dut0 (ZERO_R0=0, BYPASS=1) and dut1 (ZERO_R0=1, BYPASS=0) share stimulus.
module tb_banked_register_file;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en_a = 1'b0;
    logic [AW-1:0] rd_addr_a = '0;
    logic          rd_en_b = 1'b0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          clr_req = 1'b0;

    logic [W-1:0]  rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
    logic          rd_valid_a0, rd_valid_b0, rd_valid_a1, rd_valid_b1;
    logic          clr_busy0, clr_done0, clr_busy1, clr_done1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] qa0[$];
    logic [W-1:0] qb0[$];
    logic [W-1:0] qa1[$];
    logic [W-1:0] qb1[$];

    always #5 clk = ~clk;

    banked_register_file #(.WIDTH(W), .NUM_REGS(N), .ZERO_R0(0), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a0), .rd_valid_a(rd_valid_a0),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b0), .rd_valid_b(rd_valid_b0),
        .clr_req(clr_req), .clr_busy(clr_busy0), .clr_done(clr_done0)
    );

    banked_register_file #(.WIDTH(W), .NUM_REGS(N), .ZERO_R0(1), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a1), .rd_valid_a(rd_valid_a1),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b1), .rd_valid_b(rd_valid_b1),
        .clr_req(clr_req), .clr_busy(clr_busy1), .clr_done(clr_done1)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected word per presented valid, independent of stimulus.
    always @(negedge clk) begin
        if (rd_valid_a0) begin
            if (qa0.size() == 0) chk("dut0 A spurious valid", 32'(qa0.size()), 32'd1);
            else                 chk("dut0 A data", rd_data_a0, qa0.pop_front());
        end
        if (rd_valid_b0) begin
            if (qb0.size() == 0) chk("dut0 B spurious valid", 32'(qb0.size()), 32'd1);
            else                 chk("dut0 B data", rd_data_b0, qb0.pop_front());
        end
        if (rd_valid_a1) begin
            if (qa1.size() == 0) chk("dut1 A spurious valid", 32'(qa1.size()), 32'd1);
            else                 chk("dut1 A data", rd_data_a1, qa1.pop_front());
        end
        if (rd_valid_b1) begin
            if (qb1.size() == 0) chk("dut1 B spurious valid", 32'(qb1.size()), 32'd1);
            else                 chk("dut1 B data", rd_data_b1, qb1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Issue one read cycle; x*0 / x*1 are the hand-computed results for dut0 / dut1.
    task automatic do_read(input logic ea, input logic [AW-1:0] aa,
                           input logic [W-1:0] xa0, input logic [W-1:0] xa1,
                           input logic eb, input logic [AW-1:0] ab,
                           input logic [W-1:0] xb0, input logic [W-1:0] xb1);
        rd_en_a   = ea;
        rd_addr_a = aa;
        rd_en_b   = eb;
        rd_addr_b = ab;
        if (ea) begin qa0.push_back(xa0); qa1.push_back(xa1); end
        if (eb) begin qb0.push_back(xb0); qb1.push_back(xb1); end
        tick();
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " dut0 rd_data_a"}, rd_data_a0, '0);
        chk({tag, " dut0 rd_data_b"}, rd_data_b0, '0);
        chk({tag, " dut1 rd_data_a"}, rd_data_a1, '0);
        chk({tag, " dut1 rd_data_b"}, rd_data_b1, '0);
        chk({tag, " valids"}, 32'({rd_valid_a0, rd_valid_b0, rd_valid_a1, rd_valid_b1}), '0);
        chk({tag, " busy/done"}, 32'({clr_busy0, clr_done0, clr_busy1, clr_done1}), '0);
    endtask

    // Pulse clr_req and watch the next 30 cycles; optionally attempt a write of R2 mid-clear.
    task automatic clear_and_check(input string tag, input int wr_cycle);
        int busy0 = 0, busy1 = 0, done0 = 0, done1 = 0, first0 = 0, first1 = 0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (clr_busy0) busy0++;
            if (clr_busy1) busy1++;
            if (clr_done0) begin done0++; if (first0 == 0) first0 = c; end
            if (clr_done1) begin done1++; if (first1 == 0) first1 = c; end
            if (c == wr_cycle) begin
                wr_en   = 1'b1;
                wr_addr = 4'd2;
                wr_data = 32'hFFFF_FFFF;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        chk({tag, " dut0 busy cycles"}, 32'(busy0), 32'd16);
        chk({tag, " dut1 busy cycles"}, 32'(busy1), 32'd16);
        chk({tag, " dut0 done cycle"},  32'(first0), 32'd17);
        chk({tag, " dut1 done cycle"},  32'(first1), 32'd17);
        chk({tag, " dut0 done count"},  32'(done0), 32'd1);
        chk({tag, " dut1 done count"},  32'(done1), 32'd1);
    endtask

    initial begin
        // Reset held across two cycles: every output must be zero.
        @(negedge clk);
        chk_idle_outputs("reset c1");
        @(negedge clk);
        chk_idle_outputs("reset c2");
        tick();
        reset = 1'b1;
        do_read(1'b1, 4'd7, '0, '0, 1'b1, 4'd15, '0, '0);

        // R0 write: stored in dut0, discarded in dut1.
        do_write(4'd0, 32'hA5A5_A5A5);
        do_read(1'b1, 4'd0, 32'hA5A5_A5A5, 32'h0, 1'b0, 4'd0, '0, '0);

        // Dual read, then an idle cycle that must hold data and drop valid.
        do_write(4'd3, 32'h1234_5678);
        do_write(4'd7, 32'hDEAD_BEEF);
        do_read(1'b1, 4'd3, 32'h1234_5678, 32'h1234_5678,
                1'b1, 4'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        chk("hold dut0 A", rd_data_a0, 32'h1234_5678);
        chk("hold dut1 B", rd_data_b1, 32'hDEAD_BEEF);
        chk("hold valids", 32'({rd_valid_a0, rd_valid_b0, rd_valid_a1, rd_valid_b1}), '0);

        // Same-edge write/read of R5: forwarded in dut0, pre-write value in dut1.
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 32'hCAFE_F00D;
        do_read(1'b1, 4'd5, 32'hCAFE_F00D, 32'h0, 1'b1, 4'd3, 32'h1234_5678, 32'h1234_5678);
        wr_en = 1'b0;
        do_read(1'b1, 4'd5, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4'd0, '0, '0);

        // Fill R0..R15 and spot-check a few entries, including R0 in each config.
        for (int i = 0; i < N; i++) do_write(AW'(i), 32'h100 + 32'(i));
        do_read(1'b1, 4'd0, 32'h100, 32'h0, 1'b1, 4'd15, 32'h10F, 32'h10F);
        do_read(1'b1, 4'd2, 32'h102, 32'h102, 1'b1, 4'd9, 32'h109, 32'h109);

        // Bulk clear with a dropped write to R2 during CLEAR.
        clear_and_check("clr1", 3);
        for (int i = 0; i < N; i++) do_read(1'b1, AW'(i), '0, '0, 1'b1, AW'(N - 1 - i), '0, '0);

        // Reset on the fifth CLEAR cycle, with R12/R15 not yet reached by the clear.
        do_write(4'd12, 32'hC0C0_0012);
        do_write(4'd15, 32'hC0C0_0015);
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("pre-abort busy", 32'({clr_busy0, clr_busy1}), 32'd3);
        reset = 1'b0;
        #1;
        chk("abort dut0 busy", 32'(clr_busy0), '0);
        chk("abort dut1 busy", 32'(clr_busy1), '0);
        tick();
        tick();
        reset = 1'b1;
        do_read(1'b1, 4'd12, '0, '0, 1'b1, 4'd15, '0, '0);
        clear_and_check("clr2", 0);
        do_read(1'b1, 4'd1, '0, '0, 1'b1, 4'd14, '0, '0);

        tick();
        tick();
        chk("scoreboard drained", 32'(qa0.size() + qb0.size() + qa1.size() + qb1.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
